// File: rtl/lcd_frame_sequencer.sv
// ILI9341 frame sequencer: power-up reset/INIT/sleep-out, then per-frame window
// command launch followed by an RGB565 pixel stream over a shared SPI byte port.
module lcd_frame_sequencer #(
    parameter int DW           = 8,
    parameter int RST_LOW_CYC  = 10000,
    parameter int RST_WAIT_CYC = 500000,
    parameter int SLP_WAIT_CYC = 12000000,
    parameter int H_PIX        = 240,
    parameter int V_PIX        = 320
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_stop,
    output logic          o_lcd_rst_n,
    output logic          o_send_comm_ena,
    output logic          o_command,
    input  logic          i_comm_array_sent,
    input  logic          i_cmd_send,
    input  logic [DW-1:0] i_cmd_data,
    input  logic          i_cmd_dc,
    input  logic          i_cmd_cs,
    output logic          o_cmd_sent,
    input  logic          i_pix_valid,
    input  logic [15:0]   i_pix_data,
    output logic          o_pix_ready,
    output logic          o_spi_send,
    output logic [DW-1:0] o_spi_data,
    output logic          o_spi_dc,
    output logic          o_spi_cs,
    input  logic          i_spi_done,
    output logic          o_frame_done,
    output logic          o_busy
);

    localparam int NPIX = H_PIX * V_PIX;
    localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int MAXA = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAXD = (MAXA > SLP_WAIT_CYC) ? MAXA : SLP_WAIT_CYC;
    localparam int DCW  = $clog2(MAXD + 1);

    typedef enum logic [3:0] {
        IDLE, HW_RST, RST_WAIT, INIT, SLP_WAIT, WIN, PIX_HI, PIX_LO, FRM_END
    } state_t;

    state_t          state, state_nx;
    logic [DCW-1:0]  dly_cnt;
    logic [PCW-1:0]  pix_cnt;
    logic [15:0]     pix_reg;
    logic            stop_lat;
    logic            fresh;    // first cycle in the current state
    logic            hi_pend;  // high byte launched, waiting for its done
    logic            pix_take;
    logic            last_pix;

    assign last_pix = (pix_cnt == PCW'(NPIX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dly_cnt  <= '0;
            pix_cnt  <= '0;
            pix_reg  <= '0;
            stop_lat <= 1'b0;
            fresh    <= 1'b0;
            hi_pend  <= 1'b0;
        end else begin
            state   <= state_nx;
            fresh   <= (state_nx != state);
            hi_pend <= (state_nx == PIX_HI) && (hi_pend || pix_take);

            if (state_nx != state)
                dly_cnt <= '0;
            else if (state == HW_RST || state == RST_WAIT || state == SLP_WAIT)
                dly_cnt <= dly_cnt + DCW'(1);

            if (pix_take)
                pix_reg <= i_pix_data;

            if (state == WIN && state_nx == PIX_HI)
                pix_cnt <= '0;
            else if (state == PIX_LO && state_nx == PIX_HI)
                pix_cnt <= pix_cnt + PCW'(1);

            if (state_nx == IDLE)
                stop_lat <= 1'b0;
            else if (state != IDLE && i_stop)
                stop_lat <= 1'b1;
        end
    end

    always_comb begin
        state_nx        = state;
        o_lcd_rst_n     = 1'b1;
        o_send_comm_ena = 1'b0;
        o_command       = 1'b0;
        o_cmd_sent      = 1'b0;
        o_pix_ready     = 1'b0;
        o_spi_send      = 1'b0;
        o_spi_data      = '0;
        o_spi_dc        = 1'b1;
        o_spi_cs        = 1'b1;
        o_frame_done    = 1'b0;
        o_busy          = (state != IDLE);
        pix_take        = 1'b0;

        case (state)
            IDLE:
                if (i_start) state_nx = HW_RST;
            HW_RST: begin
                o_lcd_rst_n = 1'b0;
                if (dly_cnt == DCW'(RST_LOW_CYC - 1)) state_nx = RST_WAIT;
            end
            RST_WAIT:
                if (dly_cnt == DCW'(RST_WAIT_CYC - 1)) state_nx = INIT;
            INIT, WIN: begin
                o_send_comm_ena = fresh;
                o_command       = (state == WIN);
                o_spi_send      = i_cmd_send;
                o_spi_data      = i_cmd_data;
                o_spi_dc        = i_cmd_dc;
                o_spi_cs        = i_cmd_cs;
                o_cmd_sent      = i_spi_done;
                if (i_comm_array_sent) state_nx = (state == WIN) ? PIX_HI : SLP_WAIT;
            end
            SLP_WAIT:
                if (dly_cnt == DCW'(SLP_WAIT_CYC - 1)) state_nx = WIN;
            PIX_HI: begin
                o_spi_cs   = 1'b0;
                o_spi_data = DW'(pix_reg[15:8]);
                if (hi_pend) begin
                    if (i_spi_done) state_nx = PIX_LO;
                end else if (i_pix_valid) begin
                    o_pix_ready = 1'b1;
                    o_spi_send  = 1'b1;
                    o_spi_data  = DW'(i_pix_data[15:8]);
                    pix_take    = 1'b1;
                    if (i_spi_done) state_nx = PIX_LO;
                end
            end
            PIX_LO: begin
                o_spi_cs   = 1'b0;
                o_spi_data = DW'(pix_reg[7:0]);
                o_spi_send = fresh;
                if (i_spi_done) state_nx = last_pix ? FRM_END : PIX_HI;
            end
            FRM_END: begin
                o_frame_done = 1'b1;
                state_nx     = (stop_lat || i_stop) ? IDLE : WIN;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with shortened delays and a 2x2 frame.
module tb_lcd_frame_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 0, i_stop = 0;
    logic          o_lcd_rst_n, o_send_comm_ena, o_command;
    logic          i_comm_array_sent = 0;
    logic          i_cmd_send = 0;
    logic [DW-1:0] i_cmd_data = '0;
    logic          i_cmd_dc = 0, i_cmd_cs = 1;
    logic          o_cmd_sent;
    logic          i_pix_valid = 0;
    logic [15:0]   i_pix_data = '0;
    logic          o_pix_ready, o_spi_send;
    logic [DW-1:0] o_spi_data;
    logic          o_spi_dc, o_spi_cs;
    logic          i_spi_done = 0;
    logic          o_frame_done, o_busy;

    int n_cmp = 0;
    int n_err = 0;

    lcd_frame_sequencer #(
        .DW(DW), .RST_LOW_CYC(4), .RST_WAIT_CYC(6), .SLP_WAIT_CYC(8), .H_PIX(2), .V_PIX(2)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
        .o_lcd_rst_n(o_lcd_rst_n), .o_send_comm_ena(o_send_comm_ena), .o_command(o_command),
        .i_comm_array_sent(i_comm_array_sent), .i_cmd_send(i_cmd_send), .i_cmd_data(i_cmd_data),
        .i_cmd_dc(i_cmd_dc), .i_cmd_cs(i_cmd_cs), .o_cmd_sent(o_cmd_sent),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
        .o_spi_send(o_spi_send), .o_spi_data(o_spi_data), .o_spi_dc(o_spi_dc), .o_spi_cs(o_spi_cs),
        .i_spi_done(i_spi_done), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          send;
        logic [DW-1:0] data;
        logic          dc, cs, done;
        logic          e_send;
        logic [DW-1:0] e_data;
        logic          e_dc, e_cs, e_sent;
    } cmd_vec_t;

    typedef struct {
        logic [15:0]   px;
        logic          fast;   // done arrives with the high-byte launch
        logic [DW-1:0] hi, lo;
    } pix_vec_t;

    cmd_vec_t cv [4];
    pix_vec_t pv [4];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns cycles spent before o_send_comm_ena rises; leaves time inside that cycle.
    task automatic wait_ena(output int n);
        n = 0;
        while (n < 200) begin
            #1;
            if (o_send_comm_ena) break;
            n++;
            tick();
        end
        if (n >= 200) chk("ena_timeout", 32'(n), 0);
    endtask

    task automatic pulse_array_sent();
        #2 i_comm_array_sent = 1;
        tick();
        i_comm_array_sent = 0;
    endtask

    task automatic pixel(input pix_vec_t v, input string tag);
        i_pix_valid = 1; i_pix_data = v.px; i_spi_done = v.fast;
        #1;
        chk({tag, "_hi_ready"}, 32'(o_pix_ready), 1);
        chk({tag, "_hi_send"}, 32'(o_spi_send), 1);
        chk({tag, "_hi_data"}, 32'(o_spi_data), 32'(v.hi));
        chk({tag, "_hi_cs"}, 32'(o_spi_cs), 0);
        chk({tag, "_hi_dc"}, 32'(o_spi_dc), 1);
        tick();
        i_pix_valid = 0; i_pix_data = '0; i_spi_done = 0;
        if (!v.fast) begin
            #1;
            chk({tag, "_hi_hold_send"}, 32'(o_spi_send), 0);
            chk({tag, "_hi_hold_cs"}, 32'(o_spi_cs), 0);
            i_spi_done = 1;
            tick();
            i_spi_done = 0;
        end
        #1;
        chk({tag, "_lo_send"}, 32'(o_spi_send), 1);
        chk({tag, "_lo_data"}, 32'(o_spi_data), 32'(v.lo));
        chk({tag, "_lo_cs"}, 32'(o_spi_cs), 0);
        tick();
        #1;
        chk({tag, "_lo_hold_send"}, 32'(o_spi_send), 0);
        i_spi_done = 1;
        tick();
        i_spi_done = 0;
    endtask

    initial begin
        int low, high, n, bad, enas;
        logic got;

        cv[0] = '{1, 8'h2A, 0, 0, 0,  1, 8'h2A, 0, 0, 0};
        cv[1] = '{0, 8'h2A, 0, 0, 1,  0, 8'h2A, 0, 0, 1};
        cv[2] = '{1, 8'h36, 1, 0, 1,  1, 8'h36, 1, 0, 1};
        cv[3] = '{0, 8'h00, 1, 1, 0,  0, 8'h00, 1, 1, 0};
        pv[0] = '{16'hF800, 0, 8'hF8, 8'h00};
        pv[1] = '{16'h07E0, 0, 8'h07, 8'hE0};
        pv[2] = '{16'h001F, 1, 8'h00, 8'h1F};
        pv[3] = '{16'hFFFF, 0, 8'hFF, 8'hFF};

        // reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_lcd_rst_n", 32'(o_lcd_rst_n), 1);
        chk("rst_cs", 32'(o_spi_cs), 1);
        chk("rst_dc", 32'(o_spi_dc), 1);
        chk("rst_data", 32'(o_spi_data), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_pulses", 32'({o_send_comm_ena, o_frame_done, o_pix_ready, o_spi_send, o_cmd_sent}), 0);
        rst = 1;

        // power-up: rst low 4 cycles, 6 wait cycles, then INIT launch
        tick();
        i_start = 1;
        tick();
        i_start = 0;
        low = 0; high = 0; got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            #1;
            if (!o_lcd_rst_n) low++;
            else if (low > 0) begin
                if (o_send_comm_ena) got = 1;
                else high++;
            end
            if (!got) tick();
        end
        chk("pwr_rst_low_cycles", 32'(low), 4);
        chk("pwr_wait_cycles", 32'(high), 6);
        chk("pwr_init_launch", 32'(got), 1);
        chk("pwr_init_cmd", 32'(o_command), 0);
        chk("pwr_busy", 32'(o_busy), 1);

        enas = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            if (o_send_comm_ena) enas++;
        end
        chk("init_single_launch", 32'(enas), 0);

        // command passthrough in INIT
        for (int i = 0; i < 4; i++) begin
            i_cmd_send = cv[i].send; i_cmd_data = cv[i].data;
            i_cmd_dc = cv[i].dc; i_cmd_cs = cv[i].cs; i_spi_done = cv[i].done;
            #1;
            chk($sformatf("pass%0d_send", i), 32'(o_spi_send), 32'(cv[i].e_send));
            chk($sformatf("pass%0d_data", i), 32'(o_spi_data), 32'(cv[i].e_data));
            chk($sformatf("pass%0d_dc", i), 32'(o_spi_dc), 32'(cv[i].e_dc));
            chk($sformatf("pass%0d_cs", i), 32'(o_spi_cs), 32'(cv[i].e_cs));
            chk($sformatf("pass%0d_sent", i), 32'(o_cmd_sent), 32'(cv[i].e_sent));
            tick();
        end
        i_cmd_send = 0; i_cmd_data = '0; i_cmd_dc = 0; i_cmd_cs = 1; i_spi_done = 0;

        // SLP_WAIT ignores the command sender, then WIN launch with LOOP array
        pulse_array_sent();
        i_cmd_send = 1; i_cmd_cs = 0; i_spi_done = 1;
        #1;
        chk("slp_cs_idle", 32'(o_spi_cs), 1);
        chk("slp_send_ignored", 32'(o_spi_send), 0);
        chk("slp_cmd_sent_zero", 32'(o_cmd_sent), 0);
        i_cmd_send = 0; i_cmd_cs = 1; i_spi_done = 0;
        wait_ena(n);
        chk("slp_wait_cycles", 32'(n), 8);
        chk("win_cmd", 32'(o_command), 1);

        // frame 1
        pulse_array_sent();
        for (int i = 0; i < 4; i++) pixel(pv[i], $sformatf("f1p%0d", i));
        #1;
        chk("f1_frame_done", 32'(o_frame_done), 1);
        chk("f1_end_cs", 32'(o_spi_cs), 1);
        tick(); #1;
        chk("f1_done_single", 32'(o_frame_done), 0);
        chk("f2_win_launch", 32'(o_send_comm_ena), 1);
        chk("f2_win_cmd", 32'(o_command), 1);

        // frame 2: stall after the first pixel, stop latched mid-frame
        pulse_array_sent();
        pixel(pv[0], "f2p0");
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            i_stop = (k == 5);
            #1;
            if (o_spi_send || o_spi_cs || o_pix_ready) bad++;
            tick();
        end
        i_stop = 0;
        chk("stall_bad_cycles", 32'(bad), 0);
        for (int i = 1; i < 4; i++) pixel(pv[i], $sformatf("f2p%0d", i));
        #1;
        chk("f2_frame_done", 32'(o_frame_done), 1);
        tick(); #1;
        chk("stop_idle_busy", 32'(o_busy), 0);
        enas = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_send_comm_ena) enas++;
            tick(); #1;
        end
        chk("stop_no_launch", 32'(enas), 0);

        // async reset while in PIX_LO, then restart
        i_start = 1;
        tick();
        i_start = 0;
        wait_ena(n);
        chk("rerun_pwr_cycles", 32'(n), 10);
        pulse_array_sent();
        wait_ena(n);
        pulse_array_sent();
        i_pix_valid = 1; i_pix_data = 16'hABCD; i_spi_done = 1;
        tick();
        i_pix_valid = 0; i_spi_done = 0;
        #1;
        chk("ar_in_pix_lo", 32'(o_spi_data), 32'h0000_00CD);
        #1 rst = 0;
        #1;
        chk("ar_cs", 32'(o_spi_cs), 1);
        chk("ar_busy", 32'(o_busy), 0);
        tick();
        chk("ar_edge_cs", 32'(o_spi_cs), 1);
        chk("ar_edge_lcd_rst_n", 32'(o_lcd_rst_n), 1);
        chk("ar_edge_busy", 32'(o_busy), 0);
        chk("ar_edge_send", 32'(o_spi_send), 0);
        #2 rst = 1;
        tick();
        i_start = 1;
        tick();
        i_start = 0;
        #1;
        chk("restart_hw_rst", 32'(o_lcd_rst_n), 0);
        chk("restart_busy", 32'(o_busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_frame_sequencer.md
Name: lcd_frame_sequencer

Overview:
- Top-level sequencer for the ILI9341 SPI display path.
- Power-up: drives the LCD hardware reset pulse, launches the INIT command array through the command sender, then waits out the sleep-out delay.
- Per frame: launches the LOOP command array (window set plus RAMWR), then streams RGB565 pixels.
- Arbitrates the single SPI byte transmitter between the command sender and the pixel stream.

Parameters:
- DW, 8, SPI byte width.
- RST_LOW_CYC, 10000, clk cycles o_lcd_rst_n is held low.
- RST_WAIT_CYC, 500000, clk cycles after reset release before INIT.
- SLP_WAIT_CYC, 12000000, clk cycles after INIT array done before the first frame (120 ms at 100 MHz).
- H_PIX, 240, pixels per line.
- V_PIX, 320, lines per frame.

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- i_start  in  1  start pulse; sampled in IDLE only
- i_stop  in  1  pulse; latched, honoured at the next frame end
- o_lcd_rst_n  out  1  LCD hardware reset, active low
- o_send_comm_ena  out  1  one-cycle launch to the command sender
- o_command  out  1  array select: 0 = INI_COMM, 1 = LOOP_COMM
- i_comm_array_sent  in  1  command sender array-complete pulse
- i_cmd_send  in  1  command sender byte request
- i_cmd_data  in  DW  command sender byte
- i_cmd_dc  in  1  command sender D/C
- i_cmd_cs  in  1  command sender CS
- o_cmd_sent  out  1  byte-done pulse back to the command sender
- i_pix_valid  in  1  pixel source valid
- i_pix_data  in  16  RGB565 pixel
- o_pix_ready  out  1  pixel accept (one-cycle)
- o_spi_send  out  1  SPI byte start
- o_spi_data  out  DW  SPI byte
- o_spi_dc  out  1  SPI D/C
- o_spi_cs  out  1  SPI CS, active low
- i_spi_done  in  1  SPI byte-complete pulse
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE, all counters 0, stop latch 0. Outputs: o_lcd_rst_n=1, o_spi_cs=1, o_spi_dc=1, o_spi_data=0; all pulse outputs, o_pix_ready and o_busy = 0.
- Reset asserted mid-operation aborts immediately to the reset values; no byte or pixel is completed.
- States: IDLE, HW_RST, RST_WAIT, INIT, SLP_WAIT, WIN, PIX_HI, PIX_LO, FRM_END.
- IDLE: i_start -> HW_RST. Stop latch cleared on entry.
- HW_RST: o_lcd_rst_n=0 for exactly RST_LOW_CYC cycles -> RST_WAIT.
- RST_WAIT: o_lcd_rst_n=1 for RST_WAIT_CYC cycles -> INIT.
- INIT:
  - On the entry cycle, o_send_comm_ena=1 for one cycle with o_command=0.
  - SPI outputs are muxed combinationally from the command sender (send, data, dc, cs); o_cmd_sent = i_spi_done.
  - i_comm_array_sent -> SLP_WAIT.
- SLP_WAIT: SLP_WAIT_CYC cycles, SPI outputs idle (cs=1) -> WIN.
- WIN:
  - Same as INIT, but with o_command=1.
  - i_comm_array_sent -> PIX_HI; pixel counter cleared.
- PIX_HI:
  - Waits for i_pix_valid. In the capture cycle: o_pix_ready=1, pixel registered, o_spi_send=1 with data = pixel[15:8].
  - Then waits for i_spi_done -> PIX_LO.
- PIX_LO:
  - On entry, o_spi_send=1 for one cycle with data = pixel[7:0].
  - On i_spi_done: if pixel count == H_PIX*V_PIX-1 -> FRM_END; else count+1 and -> PIX_HI.
- Throughout PIX_HI and PIX_LO: o_spi_cs=0, o_spi_dc=1. CS stays low between bytes.
- FRM_END: o_frame_done=1 for one cycle, cs=1. If stop is latched -> IDLE; else -> WIN. There is no reset or INIT re-run between frames.
- Pixel counter width: clog2(H_PIX*V_PIX); it never wraps within a frame.
- o_send_comm_ena is never asserted twice for the same array.
- While not in INIT or WIN, i_cmd_* inputs are ignored and o_cmd_sent=0.
- i_stop and a frame end in the same cycle: the stop takes effect at that frame end.
- i_start outside IDLE: ignored.
- i_pix_valid absent: the controller stalls in PIX_HI indefinitely, with CS held low.
- i_spi_done arriving in the same cycle as o_spi_send: treated as the byte complete.

Test Plan:
- Power-up (RST_LOW_CYC=4, RST_WAIT_CYC=6, SLP_WAIT_CYC=8) -> o_lcd_rst_n low exactly 4 cycles. 6 cycles later, o_send_comm_ena pulses once with o_command=0.
- Command passthrough in INIT: i_cmd_data=0x2A, dc=0, cs=0 -> o_spi_data=0x2A, dc=0, cs=0 same cycle. i_spi_done -> o_cmd_sent pulses.
- Frame (H_PIX=2, V_PIX=2), pixels 0xF800, 0x07E0, 0x001F, 0xFFFF -> SPI bytes F8 00 07 E0 00 1F FF FF, dc=1, cs=0 throughout. One o_frame_done pulse, then o_command=1 launch again.
- Pixel stall: i_pix_valid deasserted 20 cycles after the first pixel -> no o_spi_send, cs stays 0. Resume -> sequence continues correctly.
- Stop: i_stop mid-frame -> the frame completes (o_frame_done), then IDLE with o_busy=0 and no further o_send_comm_ena.
- Async reset during PIX_LO -> next edge: cs=1, o_lcd_rst_n=1, o_busy=0. A new i_start restarts from HW_RST.
